// File: rtl/instr_mem_pkg.sv
// ---------------------------------------------------------------------------
// instr_mem_pkg
// Shared definitions for the loadable instruction memory:
//   NOP_WORD_DEFAULT : word driven when no real instruction is available
//   ld_state_e       : loader FSM encoding (also exported as a debug output)
//   bytes_per_word() : number of program bytes that make up one word
// ---------------------------------------------------------------------------
package instr_mem_pkg;

   localparam logic [15:0] NOP_WORD_DEFAULT = 16'h0000;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      WRITE   = 2'd2,
      FINISH  = 2'd3
   } ld_state_e;

   function automatic int bytes_per_word(input int data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/instr_loader.sv
// ---------------------------------------------------------------------------
// instr_loader
// Byte-serial program loader. Assembles DATA_W/8 bytes (MSB first) into a
// word, then issues a one-cycle write to the instruction memory.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   ld_start/ld_base/ld_len  load request (sampled in IDLE only)
//   ld_byte/ld_byte_valid    byte source
//   ld_byte_ready            loader accepts a byte this cycle
//   ld_busy/ld_done/ld_err   status (done/err are one-cycle pulses)
//   o_we/o_waddr/o_wdata     memory write port
//   o_state                  current FSM state (debug)
//
// Handshake: a byte transfers on a rising edge where ld_byte_valid and
// ld_byte_ready are both 1. ld_byte_ready depends only on FSM state, never
// on ld_byte_valid; while it is 0 the source must hold its byte stable.
// ---------------------------------------------------------------------------
module instr_loader
   import instr_mem_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 1024,
   parameter int LEN_W  = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ld_start,
   input  logic [ADDR_W-1:0] ld_base,
   input  logic [LEN_W-1:0]  ld_len,
   input  logic [7:0]        ld_byte,
   input  logic              ld_byte_valid,
   output logic              ld_byte_ready,
   output logic              ld_busy,
   output logic              ld_done,
   output logic              ld_err,
   output logic              o_we,
   output logic [ADDR_W-1:0] o_waddr,
   output logic [DATA_W-1:0] o_wdata,
   output ld_state_e         o_state
);

   localparam int                BPW       = bytes_per_word(DATA_W);
   localparam int                CNT_W     = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BPW - 1);
   localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   ld_state_e         r_state;
   ld_state_e         w_next_state;
   logic [ADDR_W-1:0] r_addr;
   logic [LEN_W-1:0]  r_remaining;
   logic [CNT_W-1:0]  r_byte_cnt;
   logic [DATA_W-1:0] r_word;
   logic              r_err;

   logic              w_accept;
   logic              w_base_oob;
   logic [LEN_W-1:0]  w_rem_dec;

   assign w_accept   = (r_state == COLLECT) && ld_byte_valid;
   assign w_base_oob = ({1'b0, ld_base} >= DEPTH_X);
   assign w_rem_dec  = r_remaining - LEN_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state  = r_state;
      ld_busy       = (r_state != IDLE);
      ld_byte_ready = 1'b0;
      o_we          = 1'b0;
      ld_done       = 1'b0;
      ld_err        = 1'b0;
      case (r_state)
         IDLE: begin
            if (ld_start) begin
               if ((ld_len == '0) || w_base_oob) w_next_state = FINISH;
               else                              w_next_state = COLLECT;
            end
         end
         COLLECT: begin
            ld_byte_ready = 1'b1;
            if (w_accept && (r_byte_cnt == LAST_BYTE)) w_next_state = WRITE;
         end
         WRITE: begin
            o_we = 1'b1;
            // Last word written, or no room left: never wrap to address 0.
            if ((w_rem_dec == '0) || (r_addr == LAST_ADDR)) w_next_state = FINISH;
            else                                             w_next_state = COLLECT;
         end
         FINISH: begin
            ld_done      = !r_err;
            ld_err       = r_err;
            w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr      <= '0;
         r_remaining <= '0;
         r_byte_cnt  <= '0;
         r_word      <= '0;
         r_err       <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (ld_start) begin
                  r_addr      <= ld_base;
                  r_remaining <= ld_len;
                  r_byte_cnt  <= '0;
                  // An empty load finishes cleanly even with a bad base.
                  r_err       <= (ld_len != '0) && w_base_oob;
               end
            end
            COLLECT: begin
               if (w_accept) begin
                  // Shift left so the first byte ends up in the top byte lane.
                  r_word     <= (r_word << 8) | DATA_W'(ld_byte);
                  r_byte_cnt <= (r_byte_cnt == LAST_BYTE) ? '0 : r_byte_cnt + CNT_W'(1);
               end
            end
            WRITE: begin
               r_remaining <= w_rem_dec;
               if (w_rem_dec != '0) begin
                  if (r_addr == LAST_ADDR) r_err  <= 1'b1;
                  else                     r_addr <= r_addr + ADDR_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign o_waddr = r_addr;
   assign o_wdata = r_word;
   assign o_state = r_state;

endmodule

// File: rtl/instr_mem_loadable.sv
// ---------------------------------------------------------------------------
// instr_mem_loadable
// RAM-backed instruction memory with a registered fetch port and a
// byte-serial load port.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   pc, rd_en                       fetch address / enable (0 = stall)
//   instr, instr_valid, fetch_oob   registered fetch results
//   ld_*                            load request, byte handshake and status
//   o_dbg_state                     loader FSM state (debug)
// The memory array has no reset; program contents survive rst_n.
// ---------------------------------------------------------------------------
module instr_mem_loadable
   import instr_mem_pkg::*;
#(
   parameter int                DATA_W   = 16,
   parameter int                ADDR_W   = 10,
   parameter int                DEPTH    = 1024,
   parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT),
   parameter int                LEN_W    = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] pc,
   input  logic              rd_en,
   output logic [DATA_W-1:0] instr,
   output logic              instr_valid,
   output logic              fetch_oob,
   input  logic              ld_start,
   input  logic [ADDR_W-1:0] ld_base,
   input  logic [LEN_W-1:0]  ld_len,
   input  logic [7:0]        ld_byte,
   input  logic              ld_byte_valid,
   output logic              ld_byte_ready,
   output logic              ld_busy,
   output logic              ld_done,
   output logic              ld_err,
   output ld_state_e         o_dbg_state
);

   localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] r_mem [0:DEPTH-1];
   logic [DATA_W-1:0] r_instr;
   logic              r_instr_valid;
   logic              r_fetch_oob;

   logic              w_we;
   logic [ADDR_W-1:0] w_waddr;
   logic [DATA_W-1:0] w_wdata;
   logic              w_busy;
   logic              w_pc_in;

   instr_loader #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH),
      .LEN_W  (LEN_W)
   ) u_loader (
      .clk           (clk),
      .rst_n         (rst_n),
      .ld_start      (ld_start),
      .ld_base       (ld_base),
      .ld_len        (ld_len),
      .ld_byte       (ld_byte),
      .ld_byte_valid (ld_byte_valid),
      .ld_byte_ready (ld_byte_ready),
      .ld_busy       (w_busy),
      .ld_done       (ld_done),
      .ld_err        (ld_err),
      .o_we          (w_we),
      .o_waddr       (w_waddr),
      .o_wdata       (w_wdata),
      .o_state       (o_dbg_state)
   );

   assign w_pc_in = ({1'b0, pc} < DEPTH_X);

   always_ff @(posedge clk) begin
      if (w_we) r_mem[w_waddr[IDX_W-1:0]] <= w_wdata;
   end

   // Fetch path. While a load runs the array is being rewritten, so the
   // fetch stage sees NOPs regardless of rd_en; fetch_oob keeps its value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_instr       <= NOP_WORD;
         r_instr_valid <= 1'b0;
         r_fetch_oob   <= 1'b0;
      end else if (w_busy) begin
         r_instr       <= NOP_WORD;
         r_instr_valid <= 1'b0;
      end else if (rd_en) begin
         if (w_pc_in) begin
            r_instr       <= r_mem[pc[IDX_W-1:0]];
            r_instr_valid <= 1'b1;
            r_fetch_oob   <= 1'b0;
         end else begin
            r_instr       <= NOP_WORD;
            r_instr_valid <= 1'b0;
            r_fetch_oob   <= 1'b1;
         end
      end
   end

   assign instr       = r_instr;
   assign instr_valid = r_instr_valid;
   assign fetch_oob   = r_fetch_oob;
   assign ld_busy     = w_busy;

endmodule
